// File: rtl/voice_mixer_n_pkg.sv
// Shared types for the N-voice mixer: FSM state encoding and accumulator sizing.
package voice_mixer_n_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_ACCUM   = 2'd2,
    ST_OUTPUT  = 2'd3
  } mix_state_e;

  // Wide enough for NUM_VOICES products of a signed sample and a sign-extended gain.
  function automatic int acc_width(input int sample_w, input int gain_w, input int num_voices);
    return sample_w + gain_w + 1 + $clog2(num_voices) + 1;
  endfunction

endpackage

// File: rtl/voice_mixer_n_mix_saturate.sv
// Combinational signed clamp from IN_W bits down to OUT_W bits with a clipped flag.
module mix_saturate #(
  parameter int IN_W  = 28,
  parameter int OUT_W = 16
) (
  input  logic signed [IN_W-1:0]  in_val,
  output logic signed [OUT_W-1:0] out_val,
  output logic                    clipped
);

  localparam logic signed [OUT_W-1:0] MAX_V = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] MIN_V = {1'b1, {(OUT_W-1){1'b0}}};

  logic [IN_W-OUT_W:0] top_s;

  // In range only when every bit above the output sign bit matches it.
  always_comb begin
    top_s   = in_val[IN_W-1:OUT_W-1];
    out_val = in_val[OUT_W-1:0];
    clipped = 1'b0;
    if ((top_s == {(IN_W-OUT_W+1){1'b0}}) || (top_s == {(IN_W-OUT_W+1){1'b1}})) begin
      out_val = in_val[OUT_W-1:0];
      clipped = 1'b0;
    end else if (in_val[IN_W-1]) begin
      out_val = MIN_V;
      clipped = 1'b1;
    end else begin
      out_val = MAX_V;
      clipped = 1'b1;
    end
  end

endmodule

// File: rtl/voice_mixer_n.sv
// N-voice mixer: collects one sample per enabled voice per codec request, applies
// per-voice gain through a single time-shared multiplier and emits a saturated mix.
module voice_mixer_n
  import voice_mixer_n_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int SAMPLE_W   = 16,
  parameter int GAIN_W     = 8,
  parameter int SHIFT_W    = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           sample_tick,
  input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_samples,
  input  logic [NUM_VOICES-1:0]          voice_ready,
  input  logic [NUM_VOICES-1:0]          voice_enable,
  input  logic [NUM_VOICES*GAIN_W-1:0]   voice_gain,
  input  logic [SHIFT_W-1:0]             master_shift,
  input  logic                           clip_clear,
  output logic signed [SAMPLE_W-1:0]     mix_out,
  output logic                           mix_valid,
  output logic                           clip,
  output logic                           overrun,
  output logic [15:0]                    clip_count
);

  localparam int ACC_W  = acc_width(SAMPLE_W, GAIN_W, NUM_VOICES);
  localparam int IDX_W  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int TMR_W  = $clog2(TIMEOUT) + 1;
  localparam int PROD_W = SAMPLE_W + GAIN_W + 1;

  mix_state_e                 state_r, state_next_s;
  logic [NUM_VOICES-1:0]      exp_r, got_r, capture_s;
  logic signed [SAMPLE_W-1:0] hold_r [NUM_VOICES];
  logic [IDX_W-1:0]           idx_r;
  logic [TMR_W-1:0]           timer_r;
  logic signed [ACC_W-1:0]    acc_r, term_s, acc_sum_s, shifted_s;
  logic signed [PROD_W-1:0]   prod_s;
  logic [GAIN_W-1:0]          sel_gain_s;
  logic [7:0]                 shamt_s;
  logic                       collect_done_s, timeout_s, last_voice_s, fire_s;
  logic signed [SAMPLE_W-1:0] sat_val_s;
  logic                       sat_clip_s;

  // Capture strobes, window exit conditions and the shared multiply-accumulate term.
  always_comb begin
    capture_s      = {NUM_VOICES{1'b0}};
    collect_done_s = &(got_r | ~exp_r);
    timeout_s      = (timer_r == TMR_W'(TIMEOUT - 1));
    last_voice_s   = (idx_r == IDX_W'(NUM_VOICES - 1));
    fire_s         = (state_r == ST_ACCUM) && last_voice_s;
    if ((state_r == ST_IDLE) && sample_tick) begin
      capture_s = voice_ready & voice_enable;
    end else if (state_r == ST_COLLECT) begin
      capture_s = voice_ready & exp_r;
    end else begin
      capture_s = {NUM_VOICES{1'b0}};
    end
    sel_gain_s = voice_gain[int'(idx_r)*GAIN_W +: GAIN_W];
    prod_s     = PROD_W'(hold_r[idx_r]) * PROD_W'($signed({1'b0, sel_gain_s}));
    if (exp_r[idx_r] && got_r[idx_r]) begin
      term_s = ACC_W'(prod_s);
    end else begin
      term_s = {ACC_W{1'b0}};
    end
    acc_sum_s = acc_r + term_s;
    shamt_s   = 8'(GAIN_W - 1) + 8'(master_shift);
    shifted_s = acc_sum_s >>> shamt_s;
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (sample_tick) state_next_s = ST_COLLECT;
        else             state_next_s = ST_IDLE;
      end
      ST_COLLECT: begin
        if (collect_done_s || timeout_s) state_next_s = ST_ACCUM;
        else                             state_next_s = ST_COLLECT;
      end
      ST_ACCUM: begin
        if (last_voice_s) state_next_s = ST_OUTPUT;
        else              state_next_s = ST_ACCUM;
      end
      ST_OUTPUT: state_next_s = ST_IDLE;
      default:   state_next_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_r <= ST_IDLE;
    else        state_r <= state_next_s;
  end

  // Window bookkeeping, voice index and accumulator.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exp_r   <= {NUM_VOICES{1'b0}};
      got_r   <= {NUM_VOICES{1'b0}};
      timer_r <= {TMR_W{1'b0}};
      idx_r   <= {IDX_W{1'b0}};
      acc_r   <= {ACC_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (sample_tick) begin
            exp_r   <= voice_enable;
            got_r   <= capture_s;
            timer_r <= {TMR_W{1'b0}};
            idx_r   <= {IDX_W{1'b0}};
            acc_r   <= {ACC_W{1'b0}};
          end
        end
        ST_COLLECT: begin
          got_r   <= got_r | capture_s;
          timer_r <= timer_r + TMR_W'(1'b1);
        end
        ST_ACCUM: begin
          acc_r <= acc_sum_s;
          idx_r <= idx_r + IDX_W'(1'b1);
        end
        ST_OUTPUT: begin
          acc_r <= {ACC_W{1'b0}};
          idx_r <= {IDX_W{1'b0}};
        end
        default: begin
          acc_r <= {ACC_W{1'b0}};
        end
      endcase
    end
  end

  // Per-voice sample holding registers; a repeated ready overwrites.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_VOICES; i++) hold_r[i] <= {SAMPLE_W{1'b0}};
    end else begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (capture_s[i]) hold_r[i] <= voice_samples[i*SAMPLE_W +: SAMPLE_W];
      end
    end
  end

  mix_saturate #(.IN_W(ACC_W), .OUT_W(SAMPLE_W)) u_sat (
    .in_val  (shifted_s),
    .out_val (sat_val_s),
    .clipped (sat_clip_s)
  );

  // The final term is folded in on the last ACCUM edge so the strobe lands in OUTPUT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mix_out   <= {SAMPLE_W{1'b0}};
      mix_valid <= 1'b0;
      clip      <= 1'b0;
    end else if (fire_s) begin
      mix_out   <= sat_val_s;
      mix_valid <= 1'b1;
      clip      <= sat_clip_s;
    end else begin
      mix_valid <= 1'b0;
      clip      <= 1'b0;
    end
  end

  // Saturating clip counter; clear wins over a clip on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clip_count <= 16'd0;
    end else if (clip_clear) begin
      clip_count <= 16'd0;
    end else if (fire_s && sat_clip_s && (clip_count != 16'hFFFF)) begin
      clip_count <= clip_count + 16'd1;
    end else begin
      clip_count <= clip_count;
    end
  end

  assign overrun = sample_tick && (state_r != ST_IDLE);

endmodule

// File: tb/tb_voice_mixer_n.sv
// Directed bench for voice_mixer_n with a transaction-level expectation model.
module tb_voice_mixer_n;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               sample_tick = 1'b0;
  logic               clip_clear = 1'b0;
  logic [63:0]        voice_samples = 64'd0;
  logic [3:0]         voice_ready = 4'd0;
  logic [3:0]         voice_enable = 4'd0;
  logic [31:0]        voice_gain = 32'd0;
  logic [1:0]         master_shift = 2'd0;
  logic signed [15:0] mix_out;
  logic               mix_valid, clip, overrun;
  logic [15:0]        clip_count;

  voice_mixer_n dut (
    .clk(clk), .reset(rst_n), .sample_tick(sample_tick), .voice_samples(voice_samples),
    .voice_ready(voice_ready), .voice_enable(voice_enable), .voice_gain(voice_gain),
    .master_shift(master_shift), .clip_clear(clip_clear), .mix_out(mix_out),
    .mix_valid(mix_valid), .clip(clip), .overrun(overrun), .clip_count(clip_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit last_clr = 1'b0;
  always @(posedge clk) last_clr <= clip_clear;

  int checks = 0;
  int failures = 0;

  // Expected results: cycle in which mix_valid must be high, value, clip flag.
  int exp_cyc_q[$];
  int exp_val_q[$];
  bit exp_clip_q[$];
  int busy_from = -1;
  int busy_until = -2;
  int m_hold = 0;
  int m_count = 0;
  bit vexp_b, clipx_b;

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Compare process: every cycle, outputs against the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_cyc_q.delete(); exp_val_q.delete(); exp_clip_q.delete();
      m_hold = 0; m_count = 0; busy_until = -2;
      chk("rst_mix_out", mix_out, 0);
      chk("rst_mix_valid", {63'd0, mix_valid}, 0);
      chk("rst_clip", {63'd0, clip}, 0);
      chk("rst_clip_count", {48'd0, clip_count}, 0);
      chk("rst_overrun", {63'd0, overrun}, 0);
    end else begin
      while (exp_cyc_q.size() > 0 && exp_cyc_q[0] < cyc) begin
        chk("missed_valid_cycle", cyc, exp_cyc_q[0]);
        void'(exp_cyc_q.pop_front()); void'(exp_val_q.pop_front()); void'(exp_clip_q.pop_front());
      end
      vexp_b = (exp_cyc_q.size() > 0) && (exp_cyc_q[0] == cyc);
      clipx_b = 1'b0;
      if (vexp_b) begin
        m_hold  = exp_val_q[0];
        clipx_b = exp_clip_q[0];
        void'(exp_cyc_q.pop_front()); void'(exp_val_q.pop_front()); void'(exp_clip_q.pop_front());
      end
      if (last_clr) m_count = 0;
      else if (vexp_b && clipx_b && m_count < 65535) m_count++;
      chk("mix_valid", {63'd0, mix_valid}, {63'd0, vexp_b});
      chk("mix_out", mix_out, m_hold);
      chk("clip", {63'd0, clip}, {63'd0, clipx_b});
      chk("clip_count", {48'd0, clip_count}, m_count);
      chk("overrun", {63'd0, overrun},
          {63'd0, (sample_tick && cyc >= busy_from && cyc <= busy_until)});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One window: dly holds per-voice ready offset from the tick cycle, 8'hFF = never.
  task automatic run_win(input string nm, input logic [3:0] en, input logic [63:0] smp,
                         input logic [31:0] dly, input logic [31:0] gains, input logic [1:0] shf,
                         input int tick_again, input int clr_at, input int rst_at,
                         input int lit);
    int T, j, maxd, d, val;
    bit all_ok, clp;
    longint sum, sh;
    maxd = 0; all_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d = int'(dly[i*8 +: 8]);
      if (en[i]) begin
        if (d == 255) all_ok = 1'b0;
        else if (d > maxd) maxd = d;
      end
    end
    j = all_ok ? maxd + 1 : 64;
    if (j > 64) j = 64;
    sum = 0;
    for (int i = 0; i < 4; i++) begin
      d = int'(dly[i*8 +: 8]);
      if (en[i] && d != 255 && d <= j)
        sum += longint'($signed(smp[i*16 +: 16])) * longint'(gains[i*8 +: 8]);
    end
    sh  = sum >>> (7 + int'(shf));
    clp = (sh > 32767) || (sh < -32768);
    val = (sh > 32767) ? 32767 : ((sh < -32768) ? -32768 : int'(sh));

    step();
    T = cyc;
    if (rst_at <= 0) begin
      exp_cyc_q.push_back(T + j + 5); exp_val_q.push_back(val); exp_clip_q.push_back(clp);
    end
    busy_from = T + 1; busy_until = T + j + 5;
    sample_tick = 1'b1; voice_enable = en; voice_samples = smp; voice_gain = gains;
    master_shift = shf; clip_clear = (clr_at == 0);
    for (int i = 0; i < 4; i++) voice_ready[i] = (dly[i*8 +: 8] == 8'd0);
    for (int k = 1; k <= j + 6; k++) begin
      step();
      sample_tick = (k == tick_again);
      clip_clear  = (k == clr_at);
      for (int i = 0; i < 4; i++) voice_ready[i] = (int'(dly[i*8 +: 8]) == k);
      if (rst_at > 0 && k == rst_at) rst_n = 1'b0;
      if (rst_at > 0 && k == rst_at + 2) rst_n = 1'b1;
    end
    step();
    sample_tick = 1'b0; clip_clear = 1'b0; voice_ready = 4'd0;
    chk(nm, mix_out, lit);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    step(); step();
    rst_n = 1'b1;
    step(); step();
    // Unity: 4 x 1000 at gain 128, shift 2.
    run_win("lit_unity", 4'hF, {4{16'd1000}}, 32'h0, {4{8'd128}}, 2'd2, -1, -1, -1, 1000);
    run_win("lit_sat_pos", 4'hF, {4{16'h7FFF}}, 32'h0, {4{8'd255}}, 2'd0, -1, -1, -1, 32767);
    chk("lit_clip_count_1", {48'd0, clip_count}, 1);
    run_win("lit_sat_neg", 4'hF, {4{16'h8000}}, 32'h0, {4{8'd255}}, 2'd0, -1, -1, -1, -32768);
    chk("lit_clip_count_2", {48'd0, clip_count}, 2);
    // Mask: only v0 and v2 enabled, v2 late; no timeout wait.
    run_win("lit_mask", 4'b0101, {16'd0, 16'hFF9C, 16'd0, 16'd200}, 32'hFF03FF00,
            {4{8'd128}}, 2'd0, -1, -1, -1, 100);
    // Timeout: only v0 arrives, other voices carry samples that must not count.
    run_win("lit_timeout", 4'hF, {16'd3000, 16'd3000, 16'd3000, 16'd500}, 32'hFFFFFF02,
            {4{8'd128}}, 2'd0, -1, -1, -1, 500);
    // Mixed gains and a negative sum: -326500 >>> 8 = -1276.
    run_win("lit_mixed", 4'hF, {16'hF060, 16'd3000, 16'd100, 16'd1000}, 32'h00010002,
            {8'd200, 8'd128, 8'd255, 8'd64}, 2'd1, -1, -1, -1, -1276);
    // Overrun: second tick during COLLECT, exactly one output.
    run_win("lit_overrun", 4'b0011, {16'd0, 16'd0, 16'd300, 16'd100}, 32'hFFFF0501,
            {4{8'd128}}, 2'd1, 3, -1, -1, 200);
    // Reset during ACCUM aborts the window.
    run_win("lit_reset_mix_out", 4'hF, {4{16'd1000}}, 32'h0, {4{8'd128}}, 2'd2, -1, -1, 3, 0);
    chk("lit_reset_clip_count", {48'd0, clip_count}, 0);
    run_win("lit_after_reset", 4'hF, {4{16'h7FFF}}, 32'h0, {4{8'd255}}, 2'd0, -1, -1, -1, 32767);
    chk("lit_clip_count_after_reset", {48'd0, clip_count}, 1);
    // clip_clear on the very edge that registers a clip.
    run_win("lit_clr_sat", 4'hF, {4{16'h7FFF}}, 32'h0, {4{8'd255}}, 2'd0, -1, 5, -1, 32767);
    chk("lit_clip_clear_wins", {48'd0, clip_count}, 0);
    for (int i = 0; i < 8; i++) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
